alu_sequencer: RTL and testbench

Front-end controller for alu_datapath. Accepts one operation request (opcode plus two operands) over a valid/ready handshake. Serialises the operands onto the shared alu_data bus with store_a/store_b, pulses start, and waits for alu_done. Returns result, overflow and timeout status over a valid/ready response channel; one operation is in flight at a time.

---
 rtl/alu_sequencer.sv | 161 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Front-end sequencer for alu_datapath: takes one request, drives the operand bus,
// strobes and start pulse, waits for completion or timeout and returns a response.
module alu_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_opcode,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_timeout,
  output logic [DATA_WIDTH-1:0] alu_data,
  output logic [1:0]            opcode_value,
  output logic                  store_a,
  output logic                  store_b,
  output logic                  start,
  input  logic                  alu_done,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  overflow
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t                state_r, state_nx_s;
  logic [7:0]            cnt_r, cnt_nx_s;
  logic [1:0]            op_r, op_nx_s;
  logic [DATA_WIDTH-1:0] a_r, a_nx_s, b_r, b_nx_s;
  logic [DATA_WIDTH-1:0] rsp_result_r, res_nx_s;
  logic                  rsp_overflow_r, ovf_nx_s;
  logic                  rsp_timeout_r, to_nx_s;
  logic                  req_ready_r, rsp_valid_r, store_a_r, store_b_r, start_r;
  logic [DATA_WIDTH-1:0] alu_data_r, data_nx_s;

  // Next-state, captured operands and response fields
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    op_nx_s    = op_r;
    a_nx_s     = a_r;
    b_nx_s     = b_r;
    res_nx_s   = rsp_result_r;
    ovf_nx_s   = rsp_overflow_r;
    to_nx_s    = rsp_timeout_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid && req_ready_r) begin
          state_nx_s = S_LOAD_A;
          op_nx_s    = req_opcode;
          a_nx_s     = req_a;
          b_nx_s     = req_b;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_LOAD_A: state_nx_s = S_LOAD_B;
      S_LOAD_B: state_nx_s = S_START;
      S_START: begin
        cnt_nx_s   = 8'd0;
        state_nx_s = S_WAIT;
      end
      S_WAIT: begin
        cnt_nx_s = cnt_r + 8'd1;
        // completion wins over a timeout landing in the same cycle
        if (alu_done) begin
          res_nx_s   = result;
          ovf_nx_s   = overflow & ~op_r[1];
          to_nx_s    = 1'b0;
          state_nx_s = S_RESP;
        end else if (cnt_r == TO_LAST) begin
          res_nx_s   = {DATA_WIDTH{1'b0}};
          ovf_nx_s   = 1'b0;
          to_nx_s    = 1'b1;
          state_nx_s = S_RESP;
        end else begin
          state_nx_s = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_RESP;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Operand bus value for the upcoming state
  always_comb begin
    data_nx_s = {DATA_WIDTH{1'b0}};
    case (state_nx_s)
      S_LOAD_A: data_nx_s = a_nx_s;
      S_LOAD_B: data_nx_s = b_nx_s;
      default:  data_nx_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // State register; outputs are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= S_IDLE;
      cnt_r          <= 8'd0;
      op_r           <= 2'd0;
      a_r            <= {DATA_WIDTH{1'b0}};
      b_r            <= {DATA_WIDTH{1'b0}};
      rsp_result_r   <= {DATA_WIDTH{1'b0}};
      rsp_overflow_r <= 1'b0;
      rsp_timeout_r  <= 1'b0;
      req_ready_r    <= 1'b1;
      rsp_valid_r    <= 1'b0;
      store_a_r      <= 1'b0;
      store_b_r      <= 1'b0;
      start_r        <= 1'b0;
      alu_data_r     <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r        <= state_nx_s;
      cnt_r          <= cnt_nx_s;
      op_r           <= op_nx_s;
      a_r            <= a_nx_s;
      b_r            <= b_nx_s;
      rsp_result_r   <= res_nx_s;
      rsp_overflow_r <= ovf_nx_s;
      rsp_timeout_r  <= to_nx_s;
      req_ready_r    <= (state_nx_s == S_IDLE);
      rsp_valid_r    <= (state_nx_s == S_RESP);
      store_a_r      <= (state_nx_s == S_LOAD_A);
      store_b_r      <= (state_nx_s == S_LOAD_B);
      start_r        <= (state_nx_s == S_START);
      alu_data_r     <= data_nx_s;
    end
  end

  assign req_ready    = req_ready_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_result   = rsp_result_r;
  assign rsp_overflow = rsp_overflow_r;
  assign rsp_timeout  = rsp_timeout_r;
  assign alu_data     = alu_data_r;
  assign opcode_value = op_r;
  assign store_a      = store_a_r;
  assign store_b      = store_b_r;
  assign start        = start_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural datapath model and
// a request-level reference model for result, overflow, timeout and latency.
module tb_alu_sequencer;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk, reset, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]    req_opcode, opcode_value;
  logic [DW-1:0] req_a, req_b, rsp_result, alu_data, result;
  logic          rsp_overflow, rsp_timeout, store_a, store_b, start, alu_done, overflow;

  alu_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout), .alu_data(alu_data),
    .opcode_value(opcode_value), .store_a(store_a), .store_b(store_b), .start(start),
    .alu_done(alu_done), .result(result), .overflow(overflow));

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    logic       to;
    int         due;
  } exp_t;

  exp_t       q[$];
  int         checks = 0, errors = 0, cyc = 0;
  int         cur_delay = 0;
  int         hs_cyc = -100;
  logic [7:0] hs_a, hs_b;
  logic [1:0] hs_op;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU: {overflow, result}; PAR/COMP report a junk overflow of 1
  function automatic logic [8:0] alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s;
    case (op)
      2'd0: begin s = a + b; return {(a[7] == b[7]) && (s[7] != a[7]), s}; end
      2'd1: return {(a < b), 8'(a - b)};
      2'd2: return {1'b1, 7'd0, ^(a ^ b)};
      default: return {1'b1, ~a};
    endcase
  endfunction

  // Behavioural datapath: latches the bus on strobes, answers cur_delay cycles after start
  initial begin
    logic [7:0] buf_a, buf_b;
    logic [8:0] r9;
    int dleft;
    bit armed;
    buf_a = 8'd0; buf_b = 8'd0; dleft = 0; armed = 1'b0;
    alu_done = 1'b0; result = 8'd0; overflow = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      alu_done = 1'b0;
      if (armed) begin
        dleft--;
        if (dleft == 0) begin
          r9 = alu_ref(opcode_value, buf_a, buf_b);
          alu_done = 1'b1; result = r9[7:0]; overflow = r9[8]; armed = 1'b0;
        end
      end
      if (store_a) buf_a = alu_data;
      if (store_b) buf_b = alu_data;
      if (start && cur_delay != 0) begin armed = 1'b1; dleft = cur_delay; end
    end
  end

  // Monitor: protocol timing, scoreboard push at acceptance and compare on responses
  initial begin
    bit pend, popped;
    int nstb;
    logic [8:0] r9;
    exp_t e;
    pend = 1'b0; popped = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete(); pend = 1'b0; popped = 1'b0;
      end else begin
        if (popped) begin
          chk("rsp_valid_fall", {31'd0, rsp_valid}, 32'd0);
          chk("req_ready_rise", {31'd0, req_ready}, 32'd1);
        end
        popped = 1'b0;
        nstb = int'(store_a) + int'(store_b) + int'(start);
        if (nstb > 0) begin
          chk("strobe_onehot", nstb, 32'd1);
          chk("opcode_stable", {30'd0, opcode_value}, {30'd0, hs_op});
        end
        if (store_a) begin
          chk("store_a_cycle", cyc, hs_cyc + 1);
          chk("store_a_data", {24'd0, alu_data}, {24'd0, hs_a});
        end
        if (store_b) begin
          chk("store_b_cycle", cyc, hs_cyc + 2);
          chk("store_b_data", {24'd0, alu_data}, {24'd0, hs_b});
        end
        if (start) chk("start_cycle", cyc, hs_cyc + 3);
        if (!store_a && !store_b && alu_data != 8'd0) chk("alu_data_idle", {24'd0, alu_data}, 32'd0);
        if (rsp_valid) begin
          if (q.size() == 0) begin
            chk("rsp_spurious", 32'd1, 32'd0);
          end else begin
            e = q[0];
            if (!pend) chk("rsp_latency", cyc, e.due);
            chk("rsp_result", {24'd0, rsp_result}, {24'd0, e.res});
            chk("rsp_overflow", {31'd0, rsp_overflow}, {31'd0, e.ovf});
            chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
            chk("rsp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("rsp_opcode", {30'd0, opcode_value}, {30'd0, hs_op});
            if (rsp_ready) begin q.delete(0); popped = 1'b1; end
          end
        end
        pend = rsp_valid && !rsp_ready;
        if (req_valid && req_ready) begin
          hs_cyc = cyc; hs_a = req_a; hs_b = req_b; hs_op = req_opcode;
          r9 = alu_ref(req_opcode, req_a, req_b);
          if (cur_delay == 0 || cur_delay > TO) begin
            e.res = 8'd0; e.ovf = 1'b0; e.to = 1'b1; e.due = cyc + 4 + TO;
          end else begin
            e.res = r9[7:0]; e.ovf = req_opcode[1] ? 1'b0 : r9[8]; e.to = 1'b0; e.due = cyc + 4 + cur_delay;
          end
          q.push_back(e);
        end
      end
    end
  end

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input int d);
    @(posedge clk); #1;
    req_opcode = op; req_a = a; req_b = b; cur_delay = d; req_valid = 1'b1; rsp_ready = 1'b1;
    wait_accept();
  endtask

  task automatic wait_rsp(input bit rnd_ready);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) ok = 1'b1;
      else if (rnd_ready) begin @(posedge clk); #1; rsp_ready = 1'($urandom_range(0, 1)); end
    end
    if (!ok) chk("rsp_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values();
    chk("rst_flags", {25'd0, req_ready, rsp_valid, rsp_overflow, rsp_timeout, store_a, store_b, start}, 32'h40);
    chk("rst_result", {24'd0, rsp_result}, 32'd0);
    chk("rst_alu_data", {24'd0, alu_data}, 32'd0);
    chk("rst_opcode", {30'd0, opcode_value}, 32'd0);
  endtask

  initial begin
    int rel, nvalid;
    bit seen;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_opcode = 2'd0; req_a = 8'd0; req_b = 8'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values();

    send(2'd0, 8'h7F, 8'h01, 2);  wait_rsp(1'b0);   // ADD overflow, rsp at E0+6
    send(2'd2, 8'h01, 8'h00, 3);  wait_rsp(1'b0);   // PAR, overflow masked
    send(2'd0, 8'h12, 8'h34, 0);  wait_rsp(1'b0);   // timeout after 16 WAIT cycles
    send(2'd1, 8'h10, 8'h20, 1);  wait_rsp(1'b0);   // SUB borrow, minimum latency
    send(2'd3, 8'h5A, 8'h00, TO); wait_rsp(1'b0);   // done coincides with timeout

    // Backpressure with a queued request
    send(2'd3, 8'hC3, 8'h00, 4);
    @(posedge clk); #1 rsp_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    chk("bp_rsp_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    req_opcode = 2'd0; req_a = 8'h03; req_b = 8'h04; cur_delay = 2; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
      chk("bp_rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
      if (i < 9) @(posedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk); rel = cyc;
    @(negedge clk);
    chk("bp_accept_cycle", {31'd0, req_ready && req_valid}, 32'd1);
    chk("bp_accept_when", cyc, rel + 1);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_rsp(1'b0);

    // Reset during WAIT; the datapath answers late and must be ignored
    send(2'd0, 8'h11, 8'h22, 8);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); if (start) seen = 1'b1; end
    chk("rst_start_seen", {31'd0, seen}, 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values();
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (rsp_valid) nvalid++; end
    chk("rst_no_late_rsp", nvalid, 32'd0);
    send(2'd1, 8'h05, 8'h03, 2); wait_rsp(1'b0);

    // Randomised operations with random response backpressure
    for (int n = 0; n < 30; n++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), int'($urandom_range(1, 20)));
      wait_rsp(1'b1);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
